// File: rtl/mem_pkg.sv
// mem_pkg: FSM state type, default geometry/latencies and the latency counter width.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_e;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_BLOCK_W    = 128;
    localparam int DEF_RD_LATENCY = 4;
    localparam int DEF_WR_LATENCY = 4;
    function automatic int cnt_w(input int rd_lat, input int wr_lat);
        return $clog2((rd_lat > wr_lat ? rd_lat : wr_lat) + 1);
    endfunction
    localparam int CNT_W = cnt_w(DEF_RD_LATENCY, DEF_WR_LATENCY);
endpackage

// File: rtl/main_memory_responder_if.sv
// main_memory_responder_if: cache-controller to main-memory request/response bus.
interface main_memory_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLOCK_W = DEF_BLOCK_W
);
    logic               read_en_mem;
    logic               write_en_mem;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] wdata;
    logic [BLOCK_W-1:0] rdata;
    logic               ready_mem;
    logic               acknowledge;
    logic               busy;
    logic               proto_err;
    modport master (
        output read_en_mem, write_en_mem, addr, wdata,
        input  rdata, ready_mem, acknowledge, busy, proto_err
    );
    modport slave (
        input  read_en_mem, write_en_mem, addr, wdata,
        output rdata, ready_mem, acknowledge, busy, proto_err
    );
endinterface

// File: rtl/mem_latency_counter.sv
// mem_latency_counter: loadable down-counter; zero_o flags that this cycle's decrement reaches zero.
module mem_latency_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign zero_o = cnt_q <= W'(1);
endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency line-fill/write-back memory model.
// Optional MEM_PROTO_CHECK_EN adds a sticky protocol-violation flag.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BLOCK_W    = DEF_BLOCK_W,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int WR_LATENCY = DEF_WR_LATENCY
) (
    input logic                    clk,
    input logic                    rst_n,
    main_memory_responder_if.slave bus
);
    localparam int CW = cnt_w(RD_LATENCY, WR_LATENCY);
    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] wdata_q, rdata_q;
    logic               ready_q, ack_q, busy_q;
    logic [BLOCK_W-1:0] mem_q [2**ADDR_W];
    logic               idle_like, acc_wr, acc_rd, commit, zero;
    logic [ADDR_W-1:0]  rd_addr;
    logic [BLOCK_W-1:0] rd_line;
    assign idle_like = state_q == IDLE || state_q == RESP;
    assign acc_wr    = idle_like && bus.write_en_mem;
    assign acc_rd    = idle_like && bus.read_en_mem && !bus.write_en_mem;
    assign commit    = state_q == RESP && ack_q;
    assign rd_addr   = idle_like ? bus.addr : addr_q;
    // a latency-1 fill accepted in a write's ack cycle must see the line committed on the same edge
    assign rd_line   = (commit && addr_q == rd_addr) ? wdata_q : mem_q[rd_addr];
    mem_latency_counter #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (acc_wr || acc_rd),
        .val_i  (acc_wr ? CW'(WR_LATENCY - 1) : CW'(RD_LATENCY - 1)),
        .dec_i  (state_q == RD_WAIT || state_q == WR_WAIT),
        .zero_o (zero)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            case (state_q)
                RD_WAIT, WR_WAIT: if (zero) begin
                    state_q <= RESP;
                    busy_q  <= 1'b0;
                    ready_q <= state_q == RD_WAIT;
                    ack_q   <= state_q == WR_WAIT;
                    if (state_q == RD_WAIT) rdata_q <= rd_line;
                end
                default: begin
                    if (acc_wr || acc_rd) addr_q <= bus.addr;
                    if (acc_wr) begin
                        wdata_q <= bus.wdata;
                        state_q <= WR_LATENCY == 1 ? RESP : WR_WAIT;
                        busy_q  <= WR_LATENCY > 1;
                        ack_q   <= WR_LATENCY == 1;
                    end else if (acc_rd) begin
                        state_q <= RD_LATENCY == 1 ? RESP : RD_WAIT;
                        busy_q  <= RD_LATENCY > 1;
                        ready_q <= RD_LATENCY == 1;
                        if (RD_LATENCY == 1) rdata_q <= rd_line;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    always_ff @(posedge clk)
        if (commit) mem_q[addr_q] <= wdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.ready_mem   = ready_q;
    assign bus.acknowledge = ack_q;
    assign bus.busy        = busy_q;
`ifdef MEM_PROTO_CHECK_EN
    logic proto_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) proto_q <= 1'b0;
        else if ((busy_q && (bus.read_en_mem || bus.write_en_mem)) ||
                 (bus.read_en_mem && bus.write_en_mem) ||
                 $isunknown({bus.read_en_mem, bus.write_en_mem})) proto_q <= 1'b1;
    assign bus.proto_err = proto_q;
`else
    assign bus.proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: directed checks of the 4/4-latency responder and a 1/1-latency instance.
module tb_main_memory_responder;
`ifdef MEM_PROTO_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd = 1'b0, wr = 1'b0;
    logic [7:0]   addr = '0;
    logic [127:0] wdata = '0;
    int           checks = 0, errors = 0;
    main_memory_responder_if #(.ADDR_W(8), .BLOCK_W(128)) m ();
    main_memory_responder_if #(.ADDR_W(8), .BLOCK_W(128)) f ();
    assign m.read_en_mem  = rd;
    assign m.write_en_mem = wr;
    assign m.addr         = addr;
    assign m.wdata        = wdata;
    assign f.read_en_mem  = rd;
    assign f.write_en_mem = wr;
    assign f.addr         = addr;
    assign f.wdata        = wdata;
    main_memory_responder #(.ADDR_W(8), .BLOCK_W(128), .RD_LATENCY(4), .WR_LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m)
    );
    main_memory_responder #(.ADDR_W(8), .BLOCK_W(128), .RD_LATENCY(1), .WR_LATENCY(1)) dut_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (f)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic r, input logic w, input logic [7:0] a, input logic [127:0] d);
        rd = r;
        wr = w;
        addr = a;
        wdata = d;
        tick();
        rd = 1'b0;
        wr = 1'b0;
    endtask
    // called in cycle 1 after a request; returns in the response cycle
    task automatic expect_resp(input string tag, input int lat, input bit r);
        for (int c = 1; c <= lat; c++) begin
            chk({tag, "_busy"}, m.busy, c < lat);
            chk({tag, "_ready"}, m.ready_mem, r && c == lat);
            chk({tag, "_ack"}, m.acknowledge, !r && c == lat);
            if (c < lat) tick();
        end
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, m.ready_mem, 0);
        chk({tag, "_ack"}, m.acknowledge, 0);
        chk({tag, "_busy"}, m.busy, 0);
        chk({tag, "_rdata"}, m.rdata, 0);
        chk({tag, "_proto"}, m.proto_err, 0);
    endtask
    initial begin
        repeat (2) tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        issue(0, 1, 8'h21, 128'h21);
        expect_resp("w21", 4, 0);
        tick();
        issue(0, 1, 8'h10, 128'hA5A5);
        expect_resp("w10", 4, 0);
        tick();
        issue(1, 0, 8'h10, 0);
        expect_resp("r10", 4, 1);
        chk("r10_data", m.rdata, 128'hA5A5);
        tick();
        chk("r10_idle_ready", m.ready_mem, 0);
        chk("r10_hold", m.rdata, 128'hA5A5);
        issue(0, 1, 8'h20, 128'h2020);
        expect_resp("wb", 4, 0);
        issue(1, 0, 8'h21, 0);
        expect_resp("fill", 4, 1);
        chk("fill_data", m.rdata, 128'h21);
        issue(1, 0, 8'h20, 0);
        expect_resp("raw", 4, 1);
        chk("raw_data", m.rdata, 128'h2020);
        tick();
        issue(1, 1, 8'h30, 128'h3030);
        expect_resp("col", 4, 0);
        chk("col_proto", m.proto_err, PCHK);
        tick();
        issue(1, 0, 8'h30, 0);
        expect_resp("r30", 4, 1);
        chk("r30_data", m.rdata, 128'h3030);
        tick();
        issue(1, 0, 8'h30, 0);
        chk("drop_busy1", m.busy, 1);
        tick();
        wr = 1'b1;
        addr = 8'h30;
        wdata = 128'hBAD;
        tick();
        wr = 1'b0;
        chk("drop_busy3", m.busy, 1);
        chk("drop_ready3", m.ready_mem, 0);
        tick();
        chk("drop_ready4", m.ready_mem, 1);
        chk("drop_busy4", m.busy, 0);
        chk("drop_ack4", m.acknowledge, 0);
        chk("drop_data", m.rdata, 128'h3030);
        tick();
        chk("drop_ack5", m.acknowledge, 0);
        issue(1, 0, 8'h30, 0);
        expect_resp("r30b", 4, 1);
        chk("r30b_data", m.rdata, 128'h3030);
        tick();
        issue(0, 1, 8'h40, 128'h01D);
        expect_resp("w40", 4, 0);
        tick();
        issue(0, 1, 8'h40, 128'hEEE);
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (3) begin
            tick();
            chk("midrst_ack", m.acknowledge, 0);
        end
        rst_n = 1'b1;
        tick();
        issue(1, 0, 8'h40, 0);
        expect_resp("r40", 4, 1);
        chk("r40_data", m.rdata, 128'h01D);
        tick();
        issue(0, 1, 8'h05, 128'hF5);
        chk("f_w5_ack", f.acknowledge, 1);
        chk("f_w5_busy", f.busy, 0);
        chk("f_w5_ready", f.ready_mem, 0);
        issue(1, 0, 8'h05, 0);
        chk("f_r5_ready", f.ready_mem, 1);
        chk("f_r5_ack", f.acknowledge, 0);
        chk("f_r5_data", f.rdata, 128'hF5);
        issue(0, 1, 8'h06, 128'hF6);
        chk("f_w6_ack", f.acknowledge, 1);
        chk("f_w6_ready", f.ready_mem, 0);
        issue(1, 0, 8'h06, 0);
        chk("f_r6_ready", f.ready_mem, 1);
        chk("f_r6_data", f.rdata, 128'hF6);
        tick();
        chk("f_idle_ready", f.ready_mem, 0);
        chk("f_idle_ack", f.acknowledge, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
